// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Multi-cycle signed ALU sequencer (ADD, NEG, arithmetic SHR,
//                radix-2 shift-add MUL) with a 2*WIDTH result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [1:0]           MODE,
    input  logic [WIDTH-1:0]     OPERAND_X,
    input  logic [WIDTH-1:0]     OPERAND_Y,
    input  logic [SHW-1:0]       SHAMT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   RESULT
);

    localparam int c_AW = 2 * WIDTH;
    localparam int c_CW = SHW + 1;

    localparam logic [1:0] c_MODE_ADD = 2'b00;
    localparam logic [1:0] c_MODE_NEG = 2'b01;
    localparam logic [1:0] c_MODE_SHR = 2'b10;
    localparam logic [1:0] c_MODE_MUL = 2'b11;

    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_MUL = c_CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [SHW-1:0]     shamt_q, shamt_d;
    logic [c_AW-1:0]    acc_q, acc_d;
    logic [c_AW-1:0]    mcand_q, mcand_d;
    logic [c_CW-1:0]    cnt_q, cnt_d;
    logic [c_AW-1:0]    result_q, result_d;

    function automatic logic [c_AW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            shamt_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            x_q      <= x_d;
            y_q      <= y_d;
            shamt_q  <= shamt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        x_d      = x_q;
        y_d      = y_q;
        shamt_d  = shamt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mode_d  = MODE;
                    x_d     = OPERAND_X;
                    y_d     = OPERAND_Y;
                    shamt_d = SHAMT;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // MUL builds its product from zero; the other modes work on sext(X)
                acc_d   = (mode_q == c_MODE_MUL) ? '0 : sext(x_q);
                mcand_d = sext(x_q);
                case (mode_q)
                    c_MODE_SHR: cnt_d = (shamt_q == '0) ? c_CNT_ONE : {1'b0, shamt_q};
                    c_MODE_MUL: cnt_d = c_CNT_MUL;
                    default:    cnt_d = c_CNT_ONE;
                endcase
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (mode_q)
                    c_MODE_ADD: acc_d = acc_q + sext(y_q);
                    c_MODE_NEG: acc_d = '0 - acc_q;
                    c_MODE_SHR: begin
                        if (shamt_q != '0) begin
                            acc_d = $signed(acc_q) >>> 1;
                        end
                    end
                    default: begin
                        // Y's sign bit carries weight -2^(WIDTH-1), hence subtract on the last step
                        if (y_q[0]) begin
                            acc_d = (cnt_q == c_CNT_ONE) ? (acc_q - mcand_q) : (acc_q + mcand_q);
                        end
                        mcand_d = mcand_q << 1;
                        y_d     = y_q >> 1;
                    end
                endcase
                cnt_d = cnt_q - c_CNT_ONE;
                if (cnt_q == c_CNT_ONE) begin
                    result_d = acc_d;
                    state_d  = S_FIN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BUSY   = (state_q != S_IDLE);
    assign DONE   = (state_q == S_FIN);
    assign RESULT = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Scoreboard bench for alu_op_sequencer (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  MODE;
    logic [15:0] OPERAND_X;
    logic [15:0] OPERAND_Y;
    logic [3:0]  SHAMT;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    alu_op_sequencer #(.WIDTH(16), .SHW(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .MODE      (MODE),
        .OPERAND_X (OPERAND_X),
        .OPERAND_Y (OPERAND_Y),
        .SHAMT     (SHAMT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    int          cyc       = 0;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] prev_exp  = 32'h0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (DONE) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got DONE with RESULT %h expected no DONE (cycle %0d)", RESULT, cyc);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result_op%0d", e.tag), RESULT, e.res);
                chk($sformatf("latency_op%0d", e.tag), 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (BUSY && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (BUSY) begin
            total_cnt++;
            $display("FAIL idle_timeout: got BUSY %b expected 0 within 200 cycles", BUSY);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] sh, input logic [31:0] er, input int el, input int tag);
        wait_idle();
        MODE = m; OPERAND_X = x; OPERAND_Y = y; SHAMT = sh; START = 1'b1;
        sb.push_back('{er, el, cyc, tag});
        @(negedge CLK);
        START = 1'b0;
        OPERAND_X = x ^ 16'hA5A5; OPERAND_Y = ~y; MODE = ~m; SHAMT = ~sh;
        @(negedge CLK);
        chk($sformatf("busy_exec_op%0d", tag), {31'b0, BUSY}, 32'h1);
        chk($sformatf("result_held_op%0d", tag), RESULT, prev_exp);
        prev_exp = er;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        RST = 1'b1; START = 1'b0; MODE = 2'b00;
        OPERAND_X = '0; OPERAND_Y = '0; SHAMT = '0;
        repeat (3) @(negedge CLK);
        chk("reset_busy",   {31'b0, BUSY}, 32'h0);
        chk("reset_done",   {31'b0, DONE}, 32'h0);
        chk("reset_result", RESULT, 32'h0);
        RST = 1'b0;

        issue(2'b00, 16'h7FFF, 16'h0001, 4'd0,  32'h0000_8000, 3,  1);
        issue(2'b01, 16'h8000, 16'h1234, 4'd0,  32'h0000_8000, 3,  2);
        issue(2'b01, 16'h0001, 16'h0000, 4'd0,  32'hFFFF_FFFF, 3,  3);
        wait_idle();
        repeat (3) @(negedge CLK);
        chk("result_hold_idle", RESULT, 32'hFFFF_FFFF);

        issue(2'b10, 16'hF000, 16'h0000, 4'd4,  32'hFFFF_FF00, 6,  4);
        issue(2'b10, 16'hF000, 16'h0000, 4'd0,  32'hFFFF_F000, 3,  5);
        issue(2'b11, 16'hFFFD, 16'h0007, 4'd0,  32'hFFFF_FFEB, 18, 6);
        issue(2'b11, 16'h8000, 16'h8000, 4'd0,  32'h4000_0000, 18, 7);
        issue(2'b11, 16'h7FFF, 16'h8000, 4'd0,  32'hC000_8000, 18, 8);
        issue(2'b00, 16'h8000, 16'h8000, 4'd0,  32'hFFFF_0000, 3,  9);
        issue(2'b10, 16'h8001, 16'h0000, 4'd15, 32'hFFFF_FFFF, 17, 10);
        issue(2'b11, 16'h0003, 16'hFFFF, 4'd0,  32'hFFFF_FFFD, 18, 11);
        issue(2'b10, 16'h4000, 16'h0000, 4'd1,  32'h0000_2000, 3,  12);

        // START held through a whole MUL while operands keep changing
        wait_idle();
        MODE = 2'b11; OPERAND_X = 16'h0005; OPERAND_Y = 16'h0006; SHAMT = 4'd3; START = 1'b1;
        sb.push_back('{32'h0000_001E, 18, cyc, 13});
        k = 0;
        do begin
            @(negedge CLK);
            OPERAND_X = OPERAND_X + 16'd3;
            OPERAND_Y = OPERAND_Y + 16'd1;
            MODE      = MODE + 2'd1;
            k++;
        end while (!DONE && k < 100);
        if (!DONE) begin
            total_cnt++;
            $display("FAIL hold_done_timeout: got DONE %b expected 1 within 100 cycles", DONE);
        end
        @(negedge CLK);
        chk("fin_start_ignored", {31'b0, BUSY}, 32'h0);
        prev_exp = 32'h0000_001E;
        issue(2'b00, 16'h0010, 16'h0020, 4'd0, 32'h0000_0030, 3, 14);

        // Reset in the middle of a MUL, with START asserted during reset
        wait_idle();
        MODE = 2'b11; OPERAND_X = 16'h1234; OPERAND_Y = 16'h7777; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        chk("busy_mid_mul", {31'b0, BUSY}, 32'h1);
        RST = 1'b1; START = 1'b1; MODE = 2'b00; OPERAND_X = 16'h0002; OPERAND_Y = 16'h0003;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_busy",   {31'b0, BUSY}, 32'h0);
        chk("abort_done",   {31'b0, DONE}, 32'h0);
        chk("abort_result", RESULT, 32'h0);
        sb.push_back('{32'h0000_0005, 3, cyc, 15});
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        chk("post_reset_busy", {31'b0, BUSY}, 32'h1);

        wait_idle();
        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
